flag_branch_unit: RTL and testbench

Architectural flag register and branch-condition resolver for the 16-bit datapath. It captures the Z/N/V flags produced by the saturating ALU add/sub units and resolves conditional branches against the committed flags. A flag write and a branch request in the same cycle are interlocked so that a branch always sees the newest flags. The result handshake toward the fetch/PC logic is held until acknowledged, and the unit keeps wrap-around counters of resolved and taken branches.

---
 rtl/flag_branch_unit.sv | 109 ++++++++++
 tb/tb_flag_branch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Architectural Z/N/V flag register and branch-condition resolver.
// Resolved branches are held on br_done/br_taken until acknowledged.
module flag_branch_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic [2:0]       flag_mask,
    input  logic             zr_in,
    input  logic             neg_in,
    input  logic             ov_in,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    output logic             br_ready,
    output logic             br_done,
    output logic             br_taken,
    input  logic             br_ack,
    input  logic             flush,
    output logic             zr,
    output logic             neg,
    output logic             ov,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Handshake: a request transfers on the edge where br_valid & br_ready;
    // the result is offered on br_done and consumed on the edge where
    // br_done & br_ack. br_ready drops while flags are being written so the
    // branch is evaluated one cycle later against the new flags.

    state_t state, state_nxt;
    logic   accept;
    logic   cond_true;
    logic   taken_nxt;

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = ~zr;
            3'b001:  cond_true = zr;
            3'b010:  cond_true = ~zr & ~neg;
            3'b011:  cond_true = neg;
            3'b100:  cond_true = zr | (~zr & ~neg);
            3'b101:  cond_true = neg | zr;
            3'b110:  cond_true = ov;
            default: cond_true = 1'b1;
        endcase
    end

    assign br_ready  = ~flag_we & ~flush & ((state == IDLE) | br_ack);
    assign accept    = br_valid & br_ready;
    assign br_done   = (state == HOLD);
    assign fsm_state = state;

    always_comb begin
        state_nxt = state;
        taken_nxt = br_taken;
        if (flush) begin
            state_nxt = IDLE;
            taken_nxt = 1'b0;
        end else if (accept) begin
            state_nxt = HOLD;
            taken_nxt = cond_true;
        end else if ((state == HOLD) && br_ack) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            br_taken <= 1'b0;
        end else begin
            state    <= state_nxt;
            br_taken <= taken_nxt;
        end
    end

    // Flags are independent of flush: a squashed branch never un-commits ALU flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr  <= 1'b0;
            neg <= 1'b0;
            ov  <= 1'b0;
        end else if (flag_we) begin
            if (flag_mask[2]) zr  <= zr_in;
            if (flag_mask[1]) neg <= neg_in;
            if (flag_mask[0]) ov  <= ov_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_cnt <= '0;
            taken_cnt    <= '0;
        end else if (accept) begin
            resolved_cnt <= resolved_cnt + CNT_W'(1);
            taken_cnt    <= taken_cnt + CNT_W'(cond_true);
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed and randomized bench for flag_branch_unit against a
// transaction-level model of flags, held result and counters.
module tb_flag_branch_unit;

    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          flag_we;
    logic [2:0]    flag_mask;
    logic          zr_in, neg_in, ov_in;
    logic          br_valid;
    logic [2:0]    br_cond;
    logic          br_ready, br_done, br_taken;
    logic          br_ack;
    logic          flush;
    logic          zr, neg, ov;
    logic [CW-1:0] resolved_cnt, taken_cnt;
    logic          fsm_state;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic          m_z, m_n, m_v;
    logic          m_hold, m_taken;
    logic [CW-1:0] m_res, m_tak;
    logic          seen_ready;

    flag_branch_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask),
        .zr_in(zr_in), .neg_in(neg_in), .ov_in(ov_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_ready(br_ready),
        .br_done(br_done), .br_taken(br_taken), .br_ack(br_ack), .flush(flush),
        .zr(zr), .neg(neg), .ov(ov),
        .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Branch meaning in terms of the last compare result (Z: equal, N: less).
    function automatic logic cond_ref(input logic [2:0] c, input logic z, input logic n, input logic v);
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_z = 0; m_n = 0; m_v = 0;
        m_hold = 0; m_taken = 0;
        m_res = '0; m_tak = '0;
    endtask

    task automatic check_outputs();
        chk("br_done", br_done, m_hold);
        chk("fsm_state", fsm_state, m_hold);
        chk("flags", {zr, neg, ov}, {m_z, m_n, m_v});
        chk("resolved_cnt", resolved_cnt, m_res);
        chk("taken_cnt", taken_cnt, m_tak);
        if (m_hold) chk("br_taken", br_taken, m_taken);
    endtask

    // One clock cycle: drive, check ready mid-cycle, advance model, check after edge.
    task automatic cycle(input logic fwe, input logic [2:0] mask, input logic [2:0] fin,
                         input logic bv, input logic [2:0] bc, input logic ack, input logic fl);
        logic rdy, tk;
        flag_we = fwe; flag_mask = mask;
        zr_in = fin[2]; neg_in = fin[1]; ov_in = fin[0];
        br_valid = bv; br_cond = bc; br_ack = ack; flush = fl;
        rdy = !fwe && !fl && (!m_hold || ack);
        #1;
        seen_ready = br_ready;
        chk("br_ready", br_ready, rdy);
        tk = cond_ref(bc, m_z, m_n, m_v);
        if (fwe) begin
            if (mask[2]) m_z = fin[2];
            if (mask[1]) m_n = fin[1];
            if (mask[0]) m_v = fin[0];
        end
        if (fl) begin
            m_hold = 0;
        end else if (bv && rdy) begin
            m_hold = 1; m_taken = tk;
            m_res = m_res + 1'b1;
            m_tak = m_tak + {{(CW-1){1'b0}}, tk};
        end else if (ack) begin
            m_hold = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [CW-1:0] save_res, save_tak;
        logic          save_taken;
        int            n;

        rst_n = 0; flag_we = 0; flag_mask = 0; zr_in = 0; neg_in = 0; ov_in = 0;
        br_valid = 0; br_cond = 0; br_ack = 0; flush = 0;
        model_reset();
        #2;
        check_outputs();
        chk("reset_taken", br_taken, 1'b0);
        #10 rst_n = 1;

        // masked flag update
        cycle(1, 3'b111, 3'b101, 0, 0, 0, 0);
        chk("mask_111", {zr, neg, ov}, 3'b101);
        cycle(1, 3'b100, 3'b010, 0, 0, 0, 0);
        chk("mask_100", {zr, neg, ov}, 3'b001);

        // full condition sweep
        for (int f = 0; f < 8; f++) begin
            cycle(1, 3'b111, f[2:0], 0, 0, 0, 0);
            for (int c = 0; c < 8; c++) begin
                cycle(0, 0, 0, 1, c[2:0], 0, 0);
                cycle(0, 0, 0, 0, 0, 1, 0);
            end
        end
        chk("sweep_resolved", resolved_cnt, 16'd64);

        // interlock: flag write and EQ branch in the same cycle
        cycle(1, 3'b111, 3'b000, 0, 0, 0, 0);
        cycle(1, 3'b111, 3'b100, 1, 3'd1, 0, 0);
        chk("interlock_ready", seen_ready, 1'b0);
        cycle(0, 0, 0, 1, 3'd1, 0, 0);
        chk("interlock_ready2", seen_ready, 1'b1);
        chk("interlock_taken", br_taken, 1'b1);

        // back-to-back with ack high (Z=1,N=0,V=0)
        cycle(0, 0, 0, 1, 3'd0, 1, 0);
        chk("b2b_taken0", br_taken, 1'b0);
        cycle(0, 0, 0, 1, 3'd1, 1, 0);
        chk("b2b_taken1", br_taken, 1'b1);
        cycle(0, 0, 0, 1, 3'd6, 1, 0);
        chk("b2b_taken2", br_taken, 1'b0);
        chk("b2b_done", br_done, 1'b1);
        // stall: ack low holds result and blocks new requests
        save_taken = m_taken;
        cycle(0, 0, 0, 1, 3'd7, 0, 0);
        chk("stall_ready", seen_ready, 1'b0);
        cycle(0, 0, 0, 1, 3'd7, 0, 0);
        chk("stall_taken", br_taken, save_taken);
        cycle(0, 0, 0, 0, 0, 1, 0);
        chk("stall_release", br_done, 1'b0);

        // flush during HOLD
        cycle(0, 0, 0, 1, 3'd7, 0, 0);
        save_res = m_res; save_tak = m_tak;
        cycle(0, 0, 0, 1, 3'd7, 0, 1);
        chk("flush_ready", seen_ready, 1'b0);
        chk("flush_done", br_done, 1'b0);
        chk("flush_res", resolved_cnt, save_res);
        chk("flush_tak", taken_cnt, save_tak);
        chk("flush_flags", {zr, neg, ov}, 3'b100);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
        end

        // counter wrap
        n = int'(16'hFFFF - m_res);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, 3'($urandom_range(0, 7)), 1, 0);
        chk("wrap_ffff", resolved_cnt, 16'hFFFF);
        cycle(0, 0, 0, 1, 3'd7, 1, 0);
        chk("wrap_zero", resolved_cnt, 16'h0000);

        // asynchronous reset while holding a result
        cycle(1, 3'b111, 3'b111, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3'd7, 0, 0);
        chk("pre_reset_done", br_done, 1'b1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        chk("async_taken", br_taken, 1'b0);
        br_valid = 0; br_ack = 0;
        #2 rst_n = 1;
        #1 chk("post_reset_ready", br_ready, 1'b1);
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 1, 3'd1, 0, 0);
        chk("post_reset_eq", br_taken, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
